// File: rtl/layer2_accum_argmax.sv
// layer2_accum_argmax: layer-2 output stage. Consumes a serial stream of
// N_ACT activations per image and multiplies each one by the N_CLS class
// weights read from the layer-2 weight SRAM. The products are summed in
// N_CLS signed Q16.16 accumulators. A sequential scan then reports the
// winning class and its saturated Q8.8 score.
//
// Optional feature: define LAYER2_BIAS_EN to add i_bias_in. The
// accumulators are then preloaded with the per-class bias on start.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_start           one-cycle pulse, starts an image (IDLE only)
//   i_act_valid       activation beat valid
//   i_act_data        activation, signed Q8.8
//   o_act_ready       beat accepted this cycle when i_act_valid is high
//   o_w_re, o_w_addr  weight SRAM read enable / row (= activation index)
//   i_w_data          weight row, 1-cycle latency, lane k = [k*DW +: DW]
//   i_bias_in         per-class bias, signed Q8.8 (LAYER2_BIAS_EN only)
//   o_busy            high outside IDLE
//   o_result_valid    one-cycle result pulse
//   o_class_idx       winning class (lowest index on ties)
//   o_max_score       winning accumulator >>> 8, saturated to DW bits
module layer2_accum_argmax #(
    parameter int unsigned N_ACT = 200,
    parameter int unsigned N_CLS = 10,
    parameter int unsigned DW    = 16,
    parameter int unsigned ACC_W = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_act_valid,
    input  logic [DW-1:0]         i_act_data,
    output logic                  o_act_ready,
    output logic                  o_w_re,
    output logic [7:0]            o_w_addr,
    input  logic [N_CLS*DW-1:0]   i_w_data,
`ifdef LAYER2_BIAS_EN
    input  logic [N_CLS*DW-1:0]   i_bias_in,
`endif
    output logic                  o_busy,
    output logic                  o_result_valid,
    output logic [3:0]            o_class_idx,
    output logic [DW-1:0]         o_max_score
);

    localparam int unsigned PW       = 2 * DW;
    localparam logic [7:0]  ACT_LAST = 8'(N_ACT);
    localparam logic [3:0]  CLS_LAST = 4'(N_CLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ARGMAX, S_DONE} state_t;

    state_t                  r_state, w_next_state;
    logic                    w_act_ready, w_accept, w_clear;
    logic signed [DW-1:0]    r_s1_act;
    logic                    r_s1_valid;
    logic [7:0]              r_act_cnt;
    logic signed [ACC_W-1:0] r_acc [N_CLS];
    logic signed [PW-1:0]    w_prod [N_CLS];
    logic [3:0]              r_scan_idx, r_max_idx, w_best_idx;
    logic signed [ACC_W-1:0] r_max, w_best_val, w_shift;
    logic [ACC_W-DW:0]       w_hi;
    logic [DW-1:0]           w_sat;
    logic                    r_result_valid;
    logic [3:0]              r_class_idx;
    logic [DW-1:0]           r_max_score;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_act_ready  = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_clear      = 1'b1;
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_act_ready = (r_act_cnt < ACT_LAST);
                // Leave once the last product is being accumulated
                if (r_act_cnt == ACT_LAST && r_s1_valid) w_next_state = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (r_scan_idx == CLS_LAST) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept    = i_act_valid && w_act_ready;
    assign o_act_ready = w_act_ready;
    assign o_w_re      = w_accept;
    assign o_w_addr    = r_act_cnt;
    assign o_busy      = (r_state != S_IDLE);

    // Per-lane products of the stage-1 activation with the SRAM row
    always_comb begin
        for (int k = 0; k < int'(N_CLS); k++)
            w_prod[k] = r_s1_act * $signed(i_w_data[k*DW +: DW]);
    end

    // Running argmax; the first scan step seeds from lane 0
    always_comb begin
        w_best_val = r_max;
        w_best_idx = r_max_idx;
        if (r_scan_idx == 4'd0) begin
            w_best_val = r_acc[0];
            w_best_idx = 4'd0;
        end else if (r_acc[r_scan_idx] > r_max) begin
            w_best_val = r_acc[r_scan_idx];
            w_best_idx = r_scan_idx;
        end
    end

    // Q16.16 -> Q8.8 with saturation when the upper bits are not pure sign
    always_comb begin
        w_shift = w_best_val >>> 8;
        w_hi    = w_shift[ACC_W-1:DW-1];
        if (&w_hi || ~|w_hi) w_sat = w_shift[DW-1:0];
        else if (w_shift[ACC_W-1]) w_sat = {1'b1, {(DW-1){1'b0}}};
        else w_sat = {1'b0, {(DW-1){1'b1}}};
    end

    // Datapath: stage-1 pipeline, accumulators, scan and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_act       <= '0;
            r_s1_valid     <= 1'b0;
            r_act_cnt      <= '0;
            r_scan_idx     <= '0;
            r_max          <= '0;
            r_max_idx      <= '0;
            r_result_valid <= 1'b0;
            r_class_idx    <= '0;
            r_max_score    <= '0;
            for (int k = 0; k < int'(N_CLS); k++) r_acc[k] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_s1_valid     <= w_accept;
            if (w_accept) begin
                r_s1_act  <= $signed(i_act_data);
                r_act_cnt <= r_act_cnt + 8'd1;
            end
            if (w_clear) begin
                r_act_cnt  <= '0;
                r_scan_idx <= '0;
                for (int k = 0; k < int'(N_CLS); k++) begin
`ifdef LAYER2_BIAS_EN
                    r_acc[k] <= ACC_W'($signed(i_bias_in[k*DW +: DW])) <<< 8;
`else
                    r_acc[k] <= '0;
`endif
                end
            end else if (r_s1_valid) begin
                for (int k = 0; k < int'(N_CLS); k++)
                    r_acc[k] <= r_acc[k] + ACC_W'(w_prod[k]);
            end
            if (r_state == S_ARGMAX) begin
                r_max     <= w_best_val;
                r_max_idx <= w_best_idx;
                if (r_scan_idx == CLS_LAST) begin
                    // Result registered as the scan ends; visible during DONE
                    r_scan_idx     <= '0;
                    r_class_idx    <= w_best_idx;
                    r_max_score    <= w_sat;
                    r_result_valid <= 1'b1;
                end else begin
                    r_scan_idx <= r_scan_idx + 4'd1;
                end
            end
        end
    end

    assign o_result_valid = r_result_valid;
    assign o_class_idx    = r_class_idx;
    assign o_max_score    = r_max_score;

endmodule

// File: tb/tb_layer2_accum_argmax.sv
// Self-checking bench for layer2_accum_argmax: weight SRAM model, reference
// accumulate/argmax model and a result scoreboard.
module tb_layer2_accum_argmax;

    localparam int N_ACT = 200;
    localparam int N_CLS = 10;
    localparam int DW    = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  act_valid = 1'b0;
    logic [DW-1:0]         act_data = '0;
    logic                  act_ready, w_re, busy, result_valid;
    logic [7:0]            w_addr;
    logic [N_CLS*DW-1:0]   w_data = '0;
    logic [N_CLS*DW-1:0]   bias_in = '0;
    logic [3:0]            class_idx;
    logic [DW-1:0]         max_score;

    typedef struct { logic [3:0] idx; logic [15:0] score; } exp_t;
    exp_t sb[$];
    exp_t last_exp;

    logic signed [15:0] acts [N_ACT];
    logic signed [15:0] wmem [N_ACT][N_CLS];
    logic signed [15:0] bias [N_CLS];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    layer2_accum_argmax dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (start),
        .i_act_valid   (act_valid),
        .i_act_data    (act_data),
        .o_act_ready   (act_ready),
        .o_w_re        (w_re),
        .o_w_addr      (w_addr),
        .i_w_data      (w_data),
`ifdef LAYER2_BIAS_EN
        .i_bias_in     (bias_in),
`endif
        .o_busy        (busy),
        .o_result_valid(result_valid),
        .o_class_idx   (class_idx),
        .o_max_score   (max_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (w_re && w_addr < 8'(N_ACT))
            for (int k = 0; k < N_CLS; k++) w_data[k*DW +: DW] <= wmem[w_addr][k];
    end

    always_comb for (int k = 0; k < N_CLS; k++) bias_in[k*DW +: DW] = bias[k];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact accumulation, strict-greater argmax, >>>8 saturate
    function automatic exp_t model();
        exp_t   e;
        longint acc, best, s;
        e.idx = 0;
        best  = 0;
        for (int k = 0; k < N_CLS; k++) begin
            acc = 0;
`ifdef LAYER2_BIAS_EN
            acc = longint'(bias[k]) * 256;
`endif
            for (int i = 0; i < N_ACT; i++) acc += longint'(acts[i]) * longint'(wmem[i][k]);
            if (k == 0 || acc > best) begin
                best  = acc;
                e.idx = 4'(k);
            end
        end
        s = best >>> 8;
        if (s > 32767) e.score = 16'h7FFF;
        else if (s < -32768) e.score = 16'h8000;
        else e.score = 16'(s);
        return e;
    endfunction

    // Scoreboard consumer and latency check
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("class_idx", 64'(class_idx), 64'(e.idx));
                check("max_score", 64'(max_score), 64'(e.score));
                check("latency", 64'(cyc - last_acc_cyc), 64'd11);
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < N_ACT; i++) begin
            for (int k = 0; k < N_CLS; k++) begin
                case (mode)
                    0: wmem[i][k] = 16'(k + 1);
                    1: wmem[i][k] = (k == 3 || k == 6) ? 16'sh0080 : 16'shFF00;
                    2: wmem[i][k] = (k == 2) ? 16'sh7FFF : 16'sh0000;
                    3: wmem[i][k] = 16'sh7FFF;
                    4: wmem[i][k] = 16'($urandom_range(0, 16'hFFFF));
                    default: wmem[i][k] = 16'sh0000;
                endcase
            end
            case (mode)
                0, 1:    acts[i] = 16'sh0100;
                2:       acts[i] = 16'sh7FFF;
                3:       acts[i] = 16'sh8000;
                4:       acts[i] = 16'($urandom_range(0, 16'hFFFF));
                default: acts[i] = 16'sh0100;
            endcase
        end
    endtask

    // Drive one image; abort_at>0 resets after that many beats
    task automatic run_image(input bit bubbles, input int abort_at);
        int i, guard;
        bit acc_now;
        if (abort_at == 0) sb.push_back(model());
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_accum", 64'(busy), 64'd1);
        i = 0;
        guard = 0;
        while (i < N_ACT && guard < 2000) begin
            act_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            start     = bubbles ? ($urandom_range(0, 9) == 0) : 1'b0;
            act_data  = acts[i];
            acc_now   = act_valid;
            #1;
            check("act_ready", 64'(act_ready), 64'd1);
            check("w_re", 64'(w_re), 64'(acc_now));
            if (acc_now) check("w_addr", 64'(w_addr), 64'(i));
            @(posedge clk); #1;
            if (acc_now) begin
                i++;
                last_acc_cyc = cyc;
            end
            guard++;
            if (abort_at > 0 && i == abort_at) break;
        end
        act_valid = 1'b0;
        start     = 1'b0;
        if (guard >= 2000) check("accept_timeout", 64'(i), 64'(N_ACT));
        if (abort_at > 0) begin
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_ready", 64'(act_ready), 64'd0);
            repeat (30) @(posedge clk);
            #1;
        end else begin
            check("ready_after_last", 64'(act_ready), 64'd0);
            guard = 0;
            while (sb.size() != 0 && guard < 40) begin
                @(posedge clk); guard++;
            end
            if (sb.size() != 0) begin
                check("result_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
            last_exp = model();
            repeat (3) @(posedge clk);
            #1;
            check("hold_idx", 64'(class_idx), 64'(last_exp.idx));
            check("hold_score", 64'(max_score), 64'(last_exp.score));
            check("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < N_CLS; k++) bias[k] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_act_ready", 64'(act_ready), 64'd0);
        check("rst_w_re", 64'(w_re), 64'd0);
        check("rst_w_addr", 64'(w_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_class_idx", 64'(class_idx), 64'd0);
        check("rst_max_score", 64'(max_score), 64'd0);

        // Idle with act_valid high and no start
        act_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_w_re", 64'(w_re), 64'd0);
            check("idle_ready", 64'(act_ready), 64'd0);
        end
        @(posedge clk); #1 act_valid = 1'b0;

        fill(0); run_image(1'b0, 0);
        fill(1); run_image(1'b0, 0);
        fill(2); run_image(1'b0, 0);
        fill(3); run_image(1'b0, 0);
        fill(4); run_image(1'b0, 0);
        run_image(1'b1, 0);
        fill(4); run_image(1'b0, 50);
        run_image(1'b0, 0);
`ifdef LAYER2_BIAS_EN
        fill(5);
        for (int k = 0; k < N_CLS; k++) bias[k] = (k == 5) ? 16'sh6400 : 16'sh0000;
        run_image(1'b0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
